// File: rtl/ngp_alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package ngp_alu_pkg;
  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_NOT = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_INC = 4'd6,
    OP_DEC = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_ASR = 4'd10,
    OP_MUL = 4'd11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/ngp_alu_seq_if.sv
// Request/response handshake bundle of the sequential ALU.
interface ngp_alu_seq_if
  import ngp_alu_pkg::*;
#(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   opcode;
  logic             zy;
  logic [WIDTH-1:0] rx_reg;
  logic [WIDTH-1:0] ry_reg;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             op_err;

  modport master (
    output in_valid, opcode, zy, rx_reg, ry_reg, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, op_err
  );

  modport slave (
    input  in_valid, opcode, zy, rx_reg, ry_reg, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, op_err
  );
endinterface

// File: rtl/ngp_alu_shiftmul.sv
// Iterative datapath: one-bit-per-step shifts and, with NGP_ALU_SEQ_MUL_EN,
// a shift-add multiplier. Exposes the value the next step will produce.
module ngp_alu_shiftmul
  import ngp_alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  opcode_e          op,
  input  logic [WIDTH-1:0] x,
`ifdef NGP_ALU_SEQ_MUL_EN
  input  logic [WIDTH-1:0] y,
`endif
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] res_nxt,
  output logic             c_nxt,
  output logic             last
);
  localparam int CW = $clog2(WIDTH + 1);

  opcode_e          op_q;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_c;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_init;

  // The multiplicand walks left exactly like SHL, so MUL shares that path.
  always_comb begin
    sh_nxt = sh;
    sh_c   = 1'b0;
    case (op_q)
      OP_SHL, OP_MUL: begin sh_nxt = {sh[WIDTH-2:0], 1'b0};     sh_c = sh[WIDTH-1]; end
      OP_SHR:         begin sh_nxt = {1'b0, sh[WIDTH-1:1]};     sh_c = sh[0];       end
      OP_ASR:         begin sh_nxt = {sh[WIDTH-1], sh[WIDTH-1:1]}; sh_c = sh[0];    end
      default: ;
    endcase
  end

`ifdef NGP_ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;

  assign cnt_init = (op == OP_MUL) ? CW'(WIDTH) : CW'(amt);
  assign acc_nxt  = acc + (mq[0] ? sh : '0);
  assign res_nxt  = (op_q == OP_MUL) ? acc_nxt : sh_nxt;
  assign c_nxt    = (op_q == OP_MUL) ? 1'b0 : sh_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mq  <= '0;
      acc <= '0;
    end else if (load) begin
      mq  <= y;
      acc <= '0;
    end else if (step) begin
      mq  <= {1'b0, mq[WIDTH-1:1]};
      acc <= acc_nxt;
    end
  end
`else
  assign cnt_init = CW'(amt);
  assign res_nxt  = sh_nxt;
  assign c_nxt    = sh_c;
`endif

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= OP_AND;
      sh   <= '0;
      cnt  <= '0;
    end else if (load) begin
      op_q <= op;
      sh   <= x;
      cnt  <= cnt_init;
    end else if (step) begin
      sh   <= sh_nxt;
      cnt  <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/ngp_alu_seq.sv
// Sequential ALU top: handshake FSM, single-cycle ops and status flags.
// Build with NGP_ALU_SEQ_MUL_EN to enable opcode 11 (MUL); otherwise it is illegal.
module ngp_alu_seq
  import ngp_alu_pkg::*;
#(parameter int WIDTH = 16) (
  input logic          clk,
  input logic          rst,
  ngp_alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  opcode_e          op;
  logic [WIDTH-1:0] x, y;
  logic [SHW-1:0]   amt;
  logic             accept, is_shift, is_mul, iter_start;
  logic [WIDTH-1:0] add_b, sub_b;
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_err;
  logic [WIDTH-1:0] sm_res;
  logic             sm_c, sm_last;

  assign op       = opcode_e'(bus.opcode);
  assign x        = bus.rx_reg;
  assign y        = bus.zy ? '0 : bus.ry_reg;
  assign amt      = y[SHW-1:0];
  assign accept   = bus.in_valid && bus.in_ready;
  assign is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
`ifdef NGP_ALU_SEQ_MUL_EN
  assign is_mul   = (op == OP_MUL);
`else
  assign is_mul   = 1'b0;
`endif
  assign iter_start = is_mul || (is_shift && (amt != '0));

  // INC/DEC reuse the adder/subtractor with a constant one operand.
  assign add_b = (op == OP_INC) ? WIDTH'(1) : y;
  assign sub_b = (op == OP_DEC) ? WIDTH'(1) : y;
  assign sum   = {1'b0, x} + {1'b0, add_b};
  assign dif   = {1'b0, x} - {1'b0, sub_b};

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (op)
      OP_AND: sc_res = x & y;
      OP_OR:  sc_res = x | y;
      OP_XOR: sc_res = x ^ y;
      OP_NOT: sc_res = ~x;
      OP_ADD, OP_INC: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (x[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        sc_res = dif[WIDTH-1:0];
        sc_c   = dif[WIDTH];
        sc_v   = (x[WIDTH-1] != sub_b[WIDTH-1]) && (dif[WIDTH-1] != x[WIDTH-1]);
      end
      // Only reached with a zero shift amount: pass x through, no carry.
      OP_SHL, OP_SHR, OP_ASR: sc_res = x;
`ifdef NGP_ALU_SEQ_MUL_EN
      OP_MUL: ;
`endif
      default: sc_err = 1'b1;
    endcase
  end

  ngp_alu_shiftmul #(.WIDTH(WIDTH)) u_shiftmul (
    .clk     (clk),
    .rst     (rst),
    .load    (accept && iter_start),
    .step    (state == EXEC),
    .op      (op),
    .x       (x),
`ifdef NGP_ALU_SEQ_MUL_EN
    .y       (y),
`endif
    .amt     (amt),
    .res_nxt (sm_res),
    .c_nxt   (sm_c),
    .last    (sm_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flag_z    <= 1'b0;
      bus.flag_n    <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_v    <= 1'b0;
      bus.op_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          bus.in_ready <= 1'b0;
          if (iter_start) begin
            state <= EXEC;
          end else begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= sc_res;
            bus.flag_z    <= (sc_res == '0);
            bus.flag_n    <= sc_res[WIDTH-1];
            bus.flag_c    <= sc_c;
            bus.flag_v    <= sc_v;
            bus.op_err    <= sc_err;
          end
        end
        EXEC: if (sm_last) begin
          state         <= DONE;
          bus.out_valid <= 1'b1;
          bus.result    <= sm_res;
          bus.flag_z    <= (sm_res == '0);
          bus.flag_n    <= sm_res[WIDTH-1];
          bus.flag_c    <= sm_c;
          bus.flag_v    <= 1'b0;
          bus.op_err    <= 1'b0;
        end
        DONE: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ngp_alu_seq.sv
// Directed + randomized bench for ngp_alu_seq (WIDTH=16) against an arithmetic reference model.
module tb_ngp_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ngp_alu_seq_if #(.WIDTH(W)) bus();
  ngp_alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] res;
    logic z, n, c, v, err;
    int lat;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] x,
                                 input logic [15:0] ry, input logic zy);
    exp_t e;
    logic [15:0] y;
    int a, s;
    y = zy ? 16'h0 : ry;
    a = int'(y[3:0]);
    e.res = 16'h0; e.c = 0; e.v = 0; e.err = 0; e.lat = 1;
    case (op)
      4'd0: e.res = x & y;
      4'd1: e.res = x | y;
      4'd2: e.res = x ^ y;
      4'd3: e.res = ~x;
      4'd4: begin
        e.res = x + y;
        e.c = (int'(x) + int'(y)) > 65535;
        s = int'($signed(x)) + int'($signed(y));
        e.v = (s > 32767) || (s < -32768);
      end
      4'd5: begin
        e.res = x - y;
        e.c = x < y;
        s = int'($signed(x)) - int'($signed(y));
        e.v = (s > 32767) || (s < -32768);
      end
      4'd6: begin e.res = x + 16'd1; e.c = (x == 16'hFFFF); e.v = (x == 16'h7FFF); end
      4'd7: begin e.res = x - 16'd1; e.c = (x == 16'h0000); e.v = (x == 16'h8000); end
      4'd8: begin e.res = x << a; e.c = (a != 0) ? x[16-a] : 1'b0; e.lat = a + 1; end
      4'd9: begin e.res = x >> a; e.c = (a != 0) ? x[a-1] : 1'b0; e.lat = a + 1; end
      4'd10: begin e.res = $signed(x) >>> a; e.c = (a != 0) ? x[a-1] : 1'b0; e.lat = a + 1; end
`ifdef NGP_ALU_SEQ_MUL_EN
      4'd11: begin e.res = 16'((32'(x) * 32'(y)) & 32'hFFFF); e.lat = 17; end
`endif
      default: e.err = 1;
    endcase
    e.z = (e.res == 16'h0);
    e.n = e.res[15];
    return e;
  endfunction

  // Issue one operation, check latency and outputs, hold DONE for `hold` cycles, release.
  task automatic run_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] ry,
                        input logic zy, input int hold);
    exp_t e;
    int k, lat;
    e = model(op, x, ry, zy);
    k = 0;
    while (!bus.in_ready && k < 50) begin @(negedge clk); k++; end
    chk("in_ready_before", bus.in_ready, 1);
    bus.in_valid = 1; bus.opcode = op; bus.rx_reg = x; bus.ry_reg = ry; bus.zy = zy;
    bus.out_ready = 0;
    @(posedge clk); #1;
    // Scramble inputs: the captured operands must be unaffected.
    bus.in_valid = 0; bus.opcode = 4'($urandom); bus.rx_reg = 16'($urandom);
    bus.ry_reg = 16'($urandom); bus.zy = 1'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 100);
    chk($sformatf("lat op%0d", op), 32'(lat), 32'(e.lat));
    chk($sformatf("res op%0d", op), 32'(bus.result), 32'(e.res));
    chk($sformatf("z op%0d", op), 32'(bus.flag_z), 32'(e.z));
    chk($sformatf("n op%0d", op), 32'(bus.flag_n), 32'(e.n));
    chk($sformatf("c op%0d", op), 32'(bus.flag_c), 32'(e.c));
    chk($sformatf("v op%0d", op), 32'(bus.flag_v), 32'(e.v));
    chk($sformatf("err op%0d", op), 32'(bus.op_err), 32'(e.err));
    chk("in_ready_done", bus.in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_res", 32'(bus.result), 32'(e.res));
      chk("hold_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.op_err},
          {e.z, e.n, e.c, e.v, e.err});
      chk("hold_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_ready", bus.in_ready, 1);
  endtask

  initial begin
    bus.in_valid = 0; bus.opcode = 0; bus.zy = 0; bus.rx_reg = 0; bus.ry_reg = 0;
    bus.out_ready = 0;

    // Reset state
    #12; @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.op_err}, 0);
    chk("rst_ready", bus.in_ready, 1);
    rst = 0;

    // Directed boundary cases
    run_op(4'd4, 16'h7FFF, 16'h0001, 0, 0);
    run_op(4'd5, 16'h0000, 16'h0001, 0, 0);
    run_op(4'd5, 16'h0000, 16'h1234, 1, 0);
    run_op(4'd8, 16'h8001, 16'h0013, 0, 0);
    run_op(4'd10, 16'h8000, 16'h000F, 0, 0);
    run_op(4'd9, 16'hA5A5, 16'h0000, 0, 0);
    run_op(4'd11, 16'h00FF, 16'h0101, 0, 0);
    run_op(4'd7, 16'h8000, 16'h0000, 0, 0);
    run_op(4'd6, 16'hFFFF, 16'h0000, 0, 0);
    run_op(4'd13, 16'h1234, 16'h5678, 0, 0);
    run_op(4'd2, 16'hF0F0, 16'h0FF0, 0, 5);

    // Reset in the middle of a 15-step shift aborts it silently
    bus.in_valid = 1; bus.opcode = 4'd8; bus.rx_reg = 16'h1234; bus.ry_reg = 16'h000F; bus.zy = 0;
    @(posedge clk); #1;
    bus.in_valid = 0;
    repeat (5) @(negedge clk);
    chk("exec_valid", bus.out_valid, 0);
    chk("exec_ready", bus.in_ready, 0);
    rst = 1; #1;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_ready", bus.in_ready, 1);
    chk("abort_result", 32'(bus.result), 0);
    @(negedge clk); rst = 0;
    repeat (20) @(negedge clk);
    chk("abort_no_output", bus.out_valid, 0);
    run_op(4'd4, 16'h1111, 16'h2222, 0, 1);

    // Randomized operations
    for (int i = 0; i < 40; i++)
      run_op(4'($urandom_range(15, 0)), 16'($urandom), 16'($urandom),
             ($urandom_range(3, 0) == 0), $urandom_range(2, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
